fp_to_linear: RTL and testbench

FP_TO_LINEAR -- requirements
Module: fp_to_linear

---
 rtl/fp_to_linear.sv | 92 +++++++++
 tb/tb_fp_to_linear.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fp_to_linear.sv
// Decodes a sign/exponent/significand code to a 12-bit two's-complement linear value.
// Latency exponent+2 edges from accept; single code in flight, in_ready only while idle.
module fp_to_linear (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        sign,
   input  logic [2:0]  exponent,
   input  logic [3:0]  significand,
   output logic [11:0] analog,
   output logic        out_valid,
   input  logic        out_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      NEG   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] mag_q, mag_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        sign_q, sign_d;
   logic [11:0] analog_q, analog_d;
   logic        out_valid_q, out_valid_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mag_q       <= 12'd0;
         cnt_q       <= 3'd0;
         sign_q      <= 1'b0;
         analog_q    <= 12'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mag_q       <= mag_d;
         cnt_q       <= cnt_d;
         sign_q      <= sign_d;
         analog_q    <= analog_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mag_d       = mag_q;
      cnt_d       = cnt_q;
      sign_d      = sign_q;
      analog_d    = analog_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               mag_d   = {8'd0, significand};
               cnt_d   = exponent;
               sign_d  = sign;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q != 3'd0) begin
               mag_d = mag_q << 1;
               cnt_d = cnt_q - 3'd1;
            end else begin
               state_d = NEG;
            end
         end
         NEG: begin
            // Negating a zero magnitude yields zero, so no negative zero escapes.
            analog_d    = sign_q ? (~mag_q + 12'd1) : mag_q;
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign analog    = analog_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fp_to_linear.sv
// Directed and exhaustive checks of fp_to_linear against a linear-value reference model.
module tb_fp_to_linear;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        sign;
   logic [2:0]  exponent;
   logic [3:0]  significand;
   logic [11:0] analog;
   logic        out_valid;
   logic        out_ready;

   int total = 0;
   int bad = 0;
   int accepts = 0;
   int results = 0;
   logic [11:0] sb[$];

   fp_to_linear dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .sign(sign), .exponent(exponent), .significand(significand),
      .analog(analog), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] ref_val(input bit s, input bit [2:0] e, input bit [3:0] m);
      int v;
      logic [31:0] w;
      v = int'(m) * (1 << e);
      if (s) v = -v;
      w = v;
      return w[11:0];
   endfunction

   // Presents a code while the block is idle, records its expected result, then scrambles inputs.
   task automatic accept(input bit s, input bit [2:0] e, input bit [3:0] m);
      sign = s; exponent = e; significand = m; in_valid = 1'b1;
      @(posedge clk);
      sb.push_back(ref_val(s, e, m));
      accepts++;
      #1;
      in_valid = 1'b0;
      sign = 1'($urandom); exponent = 3'($urandom); significand = 4'($urandom);
   endtask

   task automatic wait_out(output int edges, output bit rdy_seen);
      edges = 0; rdy_seen = 1'b0;
      do begin
         @(posedge clk); #1;
         edges++;
         if (in_ready && !out_valid) rdy_seen = 1'b1;
      end while (!out_valid && edges < 40);
      if (out_valid) results++;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      sign = 1'b0; exponent = 3'd0; significand = 4'd0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (analog !== 12'h000) begin bad++; $display("FAIL reset_analog got=%h want=000", analog); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_zero;
      int ed; bit rs; logic [11:0] exp_v;
      accept(1'b0, 3'd0, 4'd0);
      wait_out(ed, rs);
      exp_v = sb.pop_front();
      total++; if (ed !== 2) begin bad++; $display("FAIL zero_latency got=%0d want=2", ed); end
      total++; if (analog !== exp_v) begin bad++; $display("FAIL zero_analog got=%h want=%h", analog, exp_v); end
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
         begin bad++; $display("FAIL zero_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
   endtask

   task automatic test_max;
      int ed; bit rs; logic [11:0] exp_v;
      accept(1'b0, 3'd7, 4'd15);
      wait_out(ed, rs);
      exp_v = sb.pop_front();
      total++; if (ed !== 9) begin bad++; $display("FAIL max_latency got=%0d want=9", ed); end
      total++; if (analog !== 12'h780 || exp_v !== 12'h780) begin bad++; $display("FAIL max_analog got=%h want=780", analog); end
      total++; if (rs !== 1'b0) begin bad++; $display("FAIL max_in_ready got=1 during conversion want=0"); end
      @(posedge clk); #1;
   endtask

   task automatic test_negative;
      int ed; bit rs; logic [11:0] exp_v;
      accept(1'b1, 3'd3, 4'd5);
      wait_out(ed, rs);
      exp_v = sb.pop_front();
      total++; if (ed !== 5) begin bad++; $display("FAIL neg_latency got=%0d want=5", ed); end
      total++; if (analog !== exp_v) begin bad++; $display("FAIL neg_analog got=%h want=%h", analog, exp_v); end
      @(posedge clk); #1;
      accept(1'b1, 3'd0, 4'd0);
      wait_out(ed, rs);
      exp_v = sb.pop_front();
      total++; if (analog !== 12'h000) begin bad++; $display("FAIL neg_zero got=%h want=000", analog); end
      @(posedge clk); #1;
   endtask

   task automatic test_hold;
      int ed; bit rs; logic [11:0] exp_v;
      out_ready = 1'b0;
      accept(1'b0, 3'd2, 4'd9);
      wait_out(ed, rs);
      exp_v = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; sign = 1'b1; exponent = 3'd5; significand = 4'd3;
         @(posedge clk); #1;
         total++; if (analog !== exp_v || out_valid !== 1'b1 || in_ready !== 1'b0)
            begin bad++; $display("FAIL hold_%0d analog=%h out_valid=%b in_ready=%b want %h/1/0", i, analog, out_valid, in_ready, exp_v); end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
         begin bad++; $display("FAIL hold_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_no_accept in_ready=%b want=1", in_ready); end
   endtask

   task automatic test_abort;
      int ed; bit rs; logic [11:0] exp_v;
      accept(1'b1, 3'd6, 4'd12);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      void'(sb.pop_front());
      accepts--;
      #1;
      total++; if (out_valid !== 1'b0 || analog !== 12'h000 || in_ready !== 1'b1)
         begin bad++; $display("FAIL abort out_valid=%b analog=%h in_ready=%b want 0/000/1", out_valid, analog, in_ready); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      accept(1'b0, 3'd1, 4'd1);
      wait_out(ed, rs);
      exp_v = sb.pop_front();
      total++; if (analog !== 12'h002 || ed !== 3)
         begin bad++; $display("FAIL after_abort analog=%h edges=%0d want 002/3", analog, ed); end
      @(posedge clk); #1;
   endtask

   task automatic test_sweep;
      int ed; bit rs; logic [11:0] exp_v;
      for (int c = 0; c < 256; c++) begin
         accept(c[7], c[6:4], c[3:0]);
         wait_out(ed, rs);
         exp_v = sb.pop_front();
         total++; if (analog !== exp_v || ed !== int'(c[6:4]) + 2)
            begin bad++; $display("FAIL sweep_code_%0d analog=%h edges=%0d want %h/%0d", c, analog, ed, exp_v, int'(c[6:4]) + 2); end
         @(posedge clk); #1;
      end
      total++; if (results !== accepts || sb.size() !== 0)
         begin bad++; $display("FAIL result_count results=%0d accepts=%0d pending=%0d", results, accepts, sb.size()); end
   endtask

   initial begin
      test_reset;
      test_zero;
      test_max;
      test_negative;
      test_hold;
      test_abort;
      test_sweep;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
